hex_display_slave: RTL and testbench

//   Avalon-MM responder that drives six active-low 7-segment displays (HEX5..HEX0) from CPU writes.
//   It is the slave end of the memory-mapped HEX path in dnn_accel_system.
//   The Nios II writes a 24-bit value plus control bits; the block decodes and blanks the digits and optionally blinks them.
//   It is instantiated inside the Qsys system, and its segment buses are exported to the board HEX pins.

---
 rtl/hex_display_slave.sv | 170 +++++++++++++++++
 tb/tb_hex_display_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_slave.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_slave
//  Description : Avalon-MM responder driving six active-low 7-segment digits
//                (HEX5..HEX0) from a 24-bit value with mask / leading-zero
//                blanking and optional blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_display_slave #(
    parameter int          BLINK_DIV = 25_000_000,
    parameter logic [31:0] ID_WORD   = 32'h4845_5830
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic        slave_waitrequest,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int                 c_CNT_W   = $clog2(BLINK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0]         c_BLANK   = 7'h7F;

    localparam logic [1:0] c_ADDR_VALUE = 2'd0;
    localparam logic [1:0] c_ADDR_CTRL  = 2'd1;
    localparam logic [1:0] c_ADDR_ADD   = 2'd2;
    localparam logic [1:0] c_ADDR_ID    = 2'd3;

    logic [23:0]        r_value;
    logic [7:0]         r_ctrl;
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic               r_rd_ack;
    logic [31:0]        r_readdata;
    logic [5:0][6:0]    r_hex;

    logic [31:0]        w_rd_mux;
    logic               w_ctrl_wr;
    logic               w_blink_off;
    logic [5:0]         w_zero_above;

    // Hex glyph lookup, segments {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = c_BLANK;
        endcase
        return seg;
    endfunction

    assign slave_waitrequest = slave_read & ~r_rd_ack;
    assign slave_readdata    = r_readdata;
    assign w_ctrl_wr         = slave_write & (slave_address == c_ADDR_CTRL);
    assign w_blink_off       = r_ctrl[7] & r_phase;

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

    // Read data source selected by word address
    always_comb begin
        w_rd_mux = 32'h0;
        case (slave_address)
            c_ADDR_VALUE: w_rd_mux = {8'h00, r_value};
            c_ADDR_CTRL:  w_rd_mux = {24'h0, r_ctrl};
            c_ADDR_ADD:   w_rd_mux = {8'h00, r_value};
            c_ADDR_ID:    w_rd_mux = ID_WORD;
            default:      w_rd_mux = 32'h0;
        endcase
    end

    // w_zero_above[i] is set when nibbles i..5 of VALUE are all zero
    always_comb begin
        w_zero_above    = 6'h00;
        w_zero_above[5] = (r_value[23:20] == 4'h0);
        for (int i = 4; i >= 0; i--) begin
            w_zero_above[i] = w_zero_above[i+1] & (r_value[4*i +: 4] == 4'h0);
        end
    end

    // Register writes; a write lands on the edge of its request cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 24'h0;
            r_ctrl  <= 8'h3F;
        end else if (slave_write) begin
            case (slave_address)
                c_ADDR_VALUE: r_value <= slave_writedata[23:0];
                c_ADDR_CTRL:  r_ctrl  <= slave_writedata[7:0];
                c_ADDR_ADD:   r_value <= r_value + slave_writedata[23:0];
                default:      ;
            endcase
        end
    end

    // One-wait-state read: capture on the first request cycle, ack the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ack   <= 1'b0;
            r_readdata <= 32'h0;
        end else if (slave_read && !r_rd_ack) begin
            r_rd_ack   <= 1'b1;
            r_readdata <= w_rd_mux;
        end else begin
            r_rd_ack   <= 1'b0;
        end
    end

    // Free-running blink divider; a CTRL write restarts it in the lit phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == c_CNT_MAX) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Registered segment outputs: mask, blink and leading-zero blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= {6{c_BLANK}};
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!r_ctrl[i] || w_blink_off ||
                    ((i != 0) && r_ctrl[6] && w_zero_above[i])) begin
                    r_hex[i] <= c_BLANK;
                end else begin
                    r_hex[i] <= f_glyph(r_value[4*i +: 4]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_display_slave
//  Description : Self-checking bench for hex_display_slave (table vectors
//                plus directed reset, wrap, ID, blink and reset-mid-read runs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_slave;

    localparam logic [31:0] c_ID = 32'h4845_5830;

    logic        clk;
    logic        rst_n;
    logic [1:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        slave_waitrequest;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_checks = 0;
    int n_errors = 0;

    hex_display_slave #(
        .BLINK_DIV (4),
        .ID_WORD   (c_ID)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .slave_readdata    (slave_readdata),
        .slave_waitrequest (slave_waitrequest),
        .hex0              (hex0),
        .hex1              (hex1),
        .hex2              (hex2),
        .hex3              (hex3),
        .hex4              (hex4),
        .hex5              (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] wdata;
        logic [41:0] exp_hex;   // {hex5,hex4,hex3,hex2,hex1,hex0}
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called and returns on a falling edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    // Called and returns on a falling edge; reports data and wait-cycle count
    task automatic rd(input logic [1:0] a, output logic [31:0] d, output int waits);
        slave_address = a;
        slave_read    = 1'b1;
        waits         = 0;
        #1;
        while (slave_waitrequest && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (slave_waitrequest) waits = 99;
        d = slave_readdata;
        @(negedge clk);
        slave_read = 1'b0;
    endtask

    task automatic chk_all_hex(input string name, input logic [6:0] exp);
        logic [41:0] act;
        act = {hex5, hex4, hex3, hex2, hex1, hex0};
        for (int d = 0; d < 6; d++) begin
            chk($sformatf("%s_hex%0d", name, d), {25'h0, act[d*7 +: 7]}, {25'h0, exp});
        end
    endtask

    initial begin
        logic [31:0] rdata;
        logic [41:0] act_hex;
        int          waits;

        vecs[0] = '{8'h3F, 32'hFFA53C91, {7'h08,7'h12,7'h30,7'h46,7'h10,7'h79}, 32'h00A53C91};
        vecs[1] = '{8'h7F, 32'h12000F00, {7'h7F,7'h7F,7'h7F,7'h0E,7'h40,7'h40}, 32'h00000F00};
        vecs[2] = '{8'h7F, 32'h00000000, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 32'h00000000};
        vecs[3] = '{8'h3F, 32'h00123456, {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02}, 32'h00123456};
        vecs[4] = '{8'h15, 32'h00789ABC, {7'h7F,7'h00,7'h7F,7'h08,7'h7F,7'h46}, 32'h00789ABC};
        vecs[5] = '{8'h3F, 32'hAAFEDCBA, {7'h0E,7'h06,7'h21,7'h46,7'h03,7'h08}, 32'h00FEDCBA};
        vecs[6] = '{8'h7F, 32'h000B0000, {7'h7F,7'h03,7'h40,7'h40,7'h40,7'h40}, 32'h000B0000};
        vecs[7] = '{8'h40, 32'h00000001, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F}, 32'h00000001};

        rst_n           = 1'b0;
        slave_address   = 2'd0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_hex("rst", 7'h7F);
        chk("rst_readdata", slave_readdata, 32'h0);
        chk("rst_waitreq", {31'h0, slave_waitrequest}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_hex("post_rst", 7'h40);
        chk("post_rst_readdata", slave_readdata, 32'h0);
        rd(2'd1, rdata, waits);
        chk("rst_ctrl", rdata, 32'h3F);
        chk("rst_ctrl_waits", waits, 1);
        rd(2'd3, rdata, waits);
        chk("id_read", rdata, c_ID);

        // Table-driven display vectors
        for (int v = 0; v < 8; v++) begin
            wr(2'd1, {24'h0, vecs[v].ctrl});
            wr(2'd0, vecs[v].wdata);
            @(negedge clk);
            act_hex = {hex5, hex4, hex3, hex2, hex1, hex0};
            for (int d = 0; d < 6; d++) begin
                chk($sformatf("vec%0d_hex%0d", v, d),
                    {25'h0, act_hex[d*7 +: 7]}, {25'h0, vecs[v].exp_hex[d*7 +: 7]});
            end
            rd(2'd0, rdata, waits);
            chk($sformatf("vec%0d_value", v), rdata, vecs[v].exp_rd);
            chk($sformatf("vec%0d_waits", v), waits, 1);
            rd(2'd1, rdata, waits);
            chk($sformatf("vec%0d_ctrl", v), rdata, {24'h0, vecs[v].ctrl});
        end

        // ADD wraps modulo 2^24; ID ignores writes
        wr(2'd0, 32'h00FFFFFE);
        wr(2'd2, 32'h00000003);
        rd(2'd0, rdata, waits);
        chk("add_wrap", rdata, 32'h00000001);
        rd(2'd2, rdata, waits);
        chk("add_readback", rdata, 32'h00000001);
        wr(2'd2, 32'hFF000010);
        rd(2'd0, rdata, waits);
        chk("add_low24_only", rdata, 32'h00000011);
        wr(2'd3, 32'hDEADBEEF);
        rd(2'd3, rdata, waits);
        chk("id_after_write", rdata, c_ID);
        rd(2'd0, rdata, waits);
        chk("value_after_id_write", rdata, 32'h00000011);

        // Blink: 4 cycles lit, 4 blank, with a one-cycle output delay
        wr(2'd0, 32'h0);
        wr(2'd1, 32'hBF);
        for (int s = 1; s <= 13; s++) begin
            @(negedge clk);
            chk($sformatf("blink_s%0d_hex0", s), {25'h0, hex0},
                {25'h0, (((s - 1) / 4) % 2 == 1) ? 7'h7F : 7'h40});
            chk($sformatf("blink_s%0d_hex5", s), {25'h0, hex5},
                {25'h0, (((s - 1) / 4) % 2 == 1) ? 7'h7F : 7'h40});
        end
        // Rewriting CTRL during the blank phase restarts lit
        wr(2'd1, 32'hBF);
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            chk($sformatf("reblink_s%0d_hex3", s), {25'h0, hex3},
                {25'h0, (s == 5) ? 7'h7F : 7'h40});
        end
        wr(2'd1, 32'h3F);

        // Reset pulse in the middle of a read drops the transaction
        slave_address = 2'd3;
        slave_read    = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_readdata", slave_readdata, 32'h0);
        chk("midrd_waitreq", {31'h0, slave_waitrequest}, 32'h1);
        chk("midrd_hex0", {25'h0, hex0}, {25'h0, 7'h7F});
        @(negedge clk);
        slave_read = 1'b0;
        rst_n      = 1'b1;
        #1;
        chk("midrd_waitreq_idle", {31'h0, slave_waitrequest}, 32'h0);
        @(negedge clk);
        rd(2'd1, rdata, waits);
        chk("after_rst_ctrl", rdata, 32'h3F);
        chk("after_rst_waits", waits, 1);
        rd(2'd0, rdata, waits);
        chk("after_rst_value", rdata, 32'h0);
        chk("after_rst_hex0", {25'h0, hex0}, {25'h0, 7'h40});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
